// File: rtl/tpu_requant_out.sv
// Requantisation stage: 4 x int32 C rows -> bias, Q31 multiply, rounding shift, offset, clamp -> 4 x int8.
// Build with REQUANT_PERCH_EN defined for per-column multiplier/shift (cfg_addr 8-15).
module tpu_requant_out #(
    parameter int ROW_BITS   = 16,
    parameter int PIPE_DEPTH = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [31:0]    cfg_wdata,
    output logic           cfg_err,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] cnt_q, cnt_d, rows_q, rows_d;
    logic [3:0][31:0]    bias_q, bias_d;
`ifdef REQUANT_PERCH_EN
    logic [3:0][31:0]    mult_q, mult_d;
    logic [3:0][5:0]     shift_q, shift_d;
`else
    logic [31:0]         mult_q, mult_d;
    logic [5:0]          shift_q, shift_d;
`endif
    logic [3:0][31:0]    col_mult;
    logic [3:0][5:0]     col_shift;
    logic [7:0]          off_q, off_d, min_q, min_d, max_q, max_d;
    logic                cfg_err_q, cfg_err_d, done_q, done_d;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [3:0][31:0]    sum_q, sum_d;
    logic [3:0][63:0]    prod_q, prod_d;
    logic [31:0]         res_q, res_d;
    logic                advance, accept;

`ifdef REQUANT_PERCH_EN
    assign col_mult  = mult_q;
    assign col_shift = shift_q;
`else
    assign col_mult  = {4{mult_q}};
    assign col_shift = {4{shift_q}};
`endif

    // Rounding shift (half up), offset and clamp; the clamp order makes act_max win when min > max.
    function automatic logic [7:0] requant(input logic [63:0] prod, input logic [5:0] sh,
                                           input logic [7:0] off, input logic [7:0] mn,
                                           input logic [7:0] mx);
        logic [5:0]         s;
        logic [64:0]        rnd;
        logic signed [64:0] t, r, v, lo, hi;
        s   = (sh < 6'd31) ? 6'd31 : sh;
        rnd = 65'd1 << (s - 6'd1);
        t   = $signed({prod[63], prod}) + $signed(rnd);
        r   = t >>> s;
        v   = r + $signed({{57{off[7]}}, off});
        lo  = $signed({{57{mn[7]}}, mn});
        hi  = $signed({{57{mx[7]}}, mx});
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v[7:0];
    endfunction

    always_comb begin
        bias_d    = bias_q;
        mult_d    = mult_q;
        shift_d   = shift_q;
        off_d     = off_q;
        min_d     = min_q;
        max_d     = max_q;
        rows_d    = rows_q;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (state_q != ST_IDLE) begin
`ifdef REQUANT_PERCH_EN
                cfg_err_d = 1'b1;
`else
                cfg_err_d = !cfg_addr[3];
`endif
            end else begin
                case (cfg_addr)
                    4'd0, 4'd1, 4'd2, 4'd3: bias_d[cfg_addr[1:0]] = cfg_wdata;
`ifdef REQUANT_PERCH_EN
                    4'd4, 4'd5: ;
`else
                    4'd4: mult_d  = cfg_wdata;
                    4'd5: shift_d = cfg_wdata[5:0];
`endif
                    4'd6: {max_d, min_d, off_d} = cfg_wdata[23:0];
                    4'd7: rows_d = cfg_wdata[ROW_BITS-1:0];
                    default: begin
`ifdef REQUANT_PERCH_EN
                        if (cfg_addr[2]) shift_d[cfg_addr[1:0]] = cfg_wdata[5:0];
                        else             mult_d[cfg_addr[1:0]]  = cfg_wdata;
`endif
                    end
                endcase
            end
        end
    end

    // The whole pipeline advances or holds together, so out_data stays stable under backpressure.
    assign advance  = !vld_q[PIPE_DEPTH-1] || out_ready;
    assign in_ready = (state_q == ST_RUN) && advance && (cnt_q != '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_d  = vld_q;
        sum_d  = sum_q;
        prod_d = prod_q;
        res_d  = res_q;
        if (advance) begin
            vld_d = {vld_q[PIPE_DEPTH-2:0], accept};
            for (int c = 0; c < 4; c++) begin
                sum_d[c]  = in_data[127-32*c -: 32] + bias_q[c];
                prod_d[c] = $signed({{32{sum_q[c][31]}}, sum_q[c]}) *
                            $signed({{32{col_mult[c][31]}}, col_mult[c]});
                res_d[31-8*c -: 8] = requant(prod_q[c], col_shift[c], off_q, min_q, max_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (rows_d != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = rows_d;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q - ROW_BITS'(1);
                    if (cnt_q == ROW_BITS'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vld_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rows_q    <= '0;
            bias_q    <= '0;
            mult_q    <= '0;
            shift_q   <= '0;
            off_q     <= '0;
            min_q     <= 8'h80;
            max_q     <= 8'h7F;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= '0;
            sum_q     <= '0;
            prod_q    <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rows_q    <= rows_d;
            bias_q    <= bias_d;
            mult_q    <= mult_d;
            shift_q   <= shift_d;
            off_q     <= off_d;
            min_q     <= min_d;
            max_q     <= max_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            sum_q     <= sum_d;
            prod_q    <= prod_d;
            res_q     <= res_d;
        end
    end

    assign out_valid = vld_q[PIPE_DEPTH-1];
    assign out_data  = res_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_tpu_requant_out.sv
// Bench for tpu_requant_out: arithmetic reference model, per-cycle scoreboard and directed scenarios.
module tb_tpu_requant_out;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [31:0]  cfg_wdata;
    logic         cfg_err;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;
    logic         done;

    tpu_requant_out #(.ROW_BITS(16), .PIPE_DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          n_out = 0;
    logic [31:0] last_out = '0;
    logic [31:0] exp_q[$];

    // Shadow of the configuration as the bench believes it was written.
    int  m_bias[4];
    int  m_mult;
    int  m_shift;
    byte m_off, m_min, m_max;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic shadow_reset();
        for (int c = 0; c < 4; c++) m_bias[c] = 0;
        m_mult = 0; m_shift = 0; m_off = 0; m_min = -128; m_max = 127;
    endtask

    function automatic logic [127:0] mk_row(input int a0, input int a1, input int a2, input int a3);
        return {a0, a1, a2, a3};
    endfunction

    // Plain integer arithmetic: floor division implements the round-half-up shift.
    function automatic logic [7:0] model_col(input int acc, input int c);
        int     sum, s;
        longint prod, den, num, q, v;
        sum  = acc + m_bias[c];
        prod = longint'(sum) * longint'(m_mult);
        s    = (m_shift < 31) ? 31 : m_shift;
        den  = 64'sd1 <<< s;
        num  = prod + den / 2;
        q    = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        v = q + longint'(m_off);
        if (m_min > m_max)       v = m_max;
        else if (v < m_min)      v = m_min;
        else if (v > m_max)      v = m_max;
        return v[7:0];
    endfunction

    function automatic logic [31:0] model_row(input logic [127:0] d);
        logic [31:0] w;
        int          acc;
        for (int c = 0; c < 4; c++) begin
            acc = d[127-32*c -: 32];
            w[31-8*c -: 8] = model_col(acc, c);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data, input bit ok);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        if (ok) begin
            case (addr)
                4'd0, 4'd1, 4'd2, 4'd3: m_bias[addr[1:0]] = data;
                4'd4: m_mult = data;
                4'd5: m_shift = int'(data[5:0]);
                4'd6: begin m_off = data[7:0]; m_min = data[15:8]; m_max = data[23:16]; end
                default: ;
            endcase
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input logic [127:0] d);
        int n = 0;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 500);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_drained"}, exp_q.size(), 32'd0);
        tick();
    endtask

    task automatic one_row(input logic [127:0] d, input logic [31:0] lit, input string name);
        cfg_write(4'd7, 32'd1, 1'b1);
        pulse_start();
        send_row(d);
        wait_done(name);
        check({name, "_dut"}, last_out, lit);
        check({name, "_model"}, model_row(d), lit);
    endtask

    // Compare process: every output transfer is checked against the model's queue.
    task automatic sb_loop();
        logic        stall_prev = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", out_data, held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_out: got %h, required no output", out_data);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("out_data", out_data, exp_v);
                        last_out = out_data;
                        n_out++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = out_data;
                if (done) done_cnt++;
                if (in_valid && in_ready) exp_q.push_back(model_row(in_data));
            end
        end
    endtask

    initial begin
        int d0, o0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        shadow_reset();
        fork sb_loop(); join_none
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single row: latency of 3 cycles and offset of -128.
        cfg_write(4'd0, 32'd24, 1'b1);
        cfg_write(4'd4, 32'h4000_0000, 1'b1);
        cfg_write(4'd5, 32'd36, 1'b1);
        cfg_write(4'd6, 32'h007F_8080, 1'b1);
        cfg_write(4'd7, 32'd1, 1'b1);
        pulse_start();
        send_row(mk_row(1000, 0, 0, 0));
        @(negedge clk); check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("lat_cycle2", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("lat_cycle3", {31'd0, out_valid}, 32'd1);
        check("t1_data", out_data, 32'h9080_8080);
        tick();
        wait_done("t1");
        check("t1_model", model_row(mk_row(1000, 0, 0, 0)), 32'h9080_8080);

        // Round half up at shift 31.
        cfg_write(4'd0, 32'd0, 1'b1);
        cfg_write(4'd5, 32'd31, 1'b1);
        cfg_write(4'd6, 32'h007F_8000, 1'b1);
        one_row(mk_row(1, -1, 3, -3), 32'h0100_02FF, "t2");

        // Activation clamp to [0, 6].
        cfg_write(4'd4, 32'h7FFF_FFFF, 1'b1);
        cfg_write(4'd6, 32'h0006_0000, 1'b1);
        one_row(mk_row(10000, -10000, 0, 5), 32'h0600_0005, "t3");

        // Four rows under backpressure; shift below 31 and a wrapping bias.
        cfg_write(4'd1, 32'hFFFF_FFCE, 1'b1);
        cfg_write(4'd2, 32'h7FFF_FFFF, 1'b1);
        cfg_write(4'd4, 32'h4000_0000, 1'b1);
        cfg_write(4'd5, 32'd20, 1'b1);
        cfg_write(4'd6, 32'h007F_8005, 1'b1);
        cfg_write(4'd7, 32'd4, 1'b1);
        d0 = done_cnt; o0 = n_out;
        pulse_start();
        fork
            begin
                send_row(mk_row(100, -100, 7, -8));
                send_row(mk_row(2000, -2000, 255, -256));
                send_row(mk_row(0, 1, 2, 3));
                send_row(mk_row(-5, 5, -7, 7));
            end
            begin
                repeat (2) tick();
                out_ready = 1'b0;
                repeat (4) tick();
                out_ready = 1'b1;
            end
        join
        wait_done("t4");
        repeat (3) tick();
        check("t4_outputs", n_out - o0, 32'd4);
        check("t4_done_once", done_cnt - d0, 32'd1);

        // Config write while running is dropped.
        cfg_write(4'd7, 32'd2, 1'b1);
        pulse_start();
        cfg_write(4'd4, 32'h1234_5678, 1'b0);
        @(negedge clk); check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        @(negedge clk); check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        tick();
        send_row(mk_row(300, -300, 40, 41));
        send_row(mk_row(-1, 0, 1, 64));
        wait_done("t5");

        // Zero rows: done next cycle, never busy.
        cfg_write(4'd7, 32'd0, 1'b1);
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        check("zero_rows_done", {31'd0, done}, 32'd1);
        check("zero_rows_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("zero_rows_done_once", done_cnt - d0, 32'd1);

        // Write of rows in the same cycle as start takes effect first.
        cfg_we = 1'b1; cfg_addr = 4'd7; cfg_wdata = 32'd1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        @(negedge clk); check("write_then_start_busy", {31'd0, busy}, 32'd1);
        tick();
        send_row(mk_row(17, 18, 19, 20));
        wait_done("t5b");

        // Reset with two rows in flight.
        cfg_write(4'd7, 32'd4, 1'b1);
        pulse_start();
        out_ready = 1'b0;
        send_row(mk_row(1, 2, 3, 4));
        send_row(mk_row(5, 6, 7, 8));
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        shadow_reset();
        tick();
        cfg_write(4'd4, 32'h7FFF_FFFF, 1'b1);
        cfg_write(4'd5, 32'd31, 1'b1);
        one_row(mk_row(1000, -1000, 50, 0), 32'h7F80_3200, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
